instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch and IF/ID pipeline stage of the Spartan mini-processor. The block owns the program counter and drives the address input of the combinational instruction ROM. It registers the returned 28-bit instruction together with its PC, splits it into fields for the decode/execute stage, and redirects fetch on taken branches and on JMP.

## Interface
Parameters:
- ADDR_WIDTH, 16, PC / ROM address width
- INSTR_WIDTH, 28, instruction width
- RESET_PC, 16'd0, PC value loaded on reset

Ports:
- Clock  input  1  single clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- oAddress  output  16  PC, drives ROM iAddress; equals PC register
- iInstruction  input  28  ROM oInstruction, valid combinationally in the same cycle as oAddress
- iStall  input  1  downstream hazard; hold PC and IF/ID register
- iBranchTaken  input  1  execute stage resolved a taken branch (BLE etc.)
- iBranchTarget  input  16  redirect address for iBranchTaken
- oValid  output  1  IF/ID register holds a real instruction
- oPC  output  16  address the IF/ID instruction was fetched from
- oOpcode  output  4  instr[27:24]
- oDest  output  8  instr[23:16] (destination register / branch/jump target)
- oSrc0  output  8  instr[15:8]
- oSrc1  output  8  instr[7:0]
- oImm16  output  16  instr[15:0]

## Operation
- PC register drives oAddress directly. The ROM lookup is combinational, so iInstruction belongs to the current PC in the same cycle.
- Each edge, the next state is chosen in this priority order:
  1. Reset: PC <= RESET_PC; oValid <= 0; all field outputs and oPC <= 0.
  2. iBranchTaken: PC <= iBranchTarget. Flush IF/ID: oValid <= 0, fields <= 0. Overrides iStall and JMP.
  3. iStall: PC and IF/ID register hold every bit unchanged.
  4. JMP in IF/ID (oValid=1 and oOpcode=`JMP): PC <= {8'b0, oDest}. IF/ID loads a bubble (oValid <= 0, fields <= 0), squashing the sequential instruction fetched this cycle.
  5. Default: IF/ID <= {iInstruction fields, PC}, oValid <= 1; PC <= PC + 1.
- The JMP itself is presented downstream with oValid=1 for one cycle. Execute treats it as a no-op.
- PC arithmetic is modulo 2^16: 16'hFFFF + 1 = 16'h0000, with no flag.
- Field extraction is pure bit slicing; no sign extension. oImm16 and {oSrc0,oSrc1} alias the same bits.
- NOP and unknown opcodes pass through unmodified. Their semantics belong to execute.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The instruction at PC=A appears on the outputs the cycle after oAddress=A, with oPC=A.
- Taken branch costs 1 bubble here. The first target instruction is valid 2 cycles after iBranchTaken is sampled.
- JMP costs 1 bubble. The target instruction is valid 2 cycles after the JMP becomes visible on the outputs.
- iStall is level-sensitive. Any number of consecutive stall cycles hold state exactly, and release resumes with no lost or duplicated instruction.
- First cycle after Reset deasserts: oAddress=RESET_PC, oValid=0. The first valid instruction appears one cycle later.
- Reset asserted mid-stall or mid-redirect wins unconditionally. Pending redirects are discarded.
- All outputs are registered, except oAddress, which is the PC register output.

## Structure
- Opcode constants (`NOP, `STO, `ADD, `BLE, `JMP, `LED, `IMUL) and field bit positions (OPCODE 27:24, DEST 23:16, SRC0 15:8, SRC1 7:0) live in the shared definitions include. The block uses them; it does not redefine them.
- Single module, no sub-module. The PC next-state mux and the IF/ID register are each one always block.

## Test plan
- Reset, then release with ROM contents 0..3 = distinct STO words → oAddress steps 0,1,2,3. oPC/oValid follow one cycle behind; oOpcode=`STO, oDest=R0, oImm16=16'd8 on the first valid cycle.
- Assert iStall for 3 cycles while oPC=5 → oAddress stays 6, oPC stays 5, oValid stays 1. After release, oPC=6 follows with no skip or repeat.
- iBranchTaken=1, iBranchTarget=8 while oPC=12 → next cycle oValid=0 and oAddress=8. The following cycle oPC=8, oValid=1.
- JMP with target 2 at address 16 → cycle after fetch: oOpcode=`JMP, oValid=1. Next cycle oValid=0, oAddress=2. Then oPC=2, oValid=1; the instruction at 17 is never valid.
- JMP in IF/ID plus iBranchTaken (target 9) plus iStall in the same cycle → PC=9 and the register is flushed, confirming branch > stall > JMP priority.
- Force PC to 16'hFFFF via branch → next fetch address 16'h0000. Reset asserted during a 5-cycle stall → PC=RESET_PC and oValid=0 on the next edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared opcode encodings and instruction field positions for the Spartan
// mini-processor. The fetch stage and its bench both import these definitions.
package instruction_fetch_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_STO  = 4'h1,
    OP_ADD  = 4'h2,
    OP_BLE  = 4'h3,
    OP_JMP  = 4'h4,
    OP_LED  = 4'h5,
    OP_IMUL = 4'h6
  } opcode_e;

  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int DEST_MSB   = 23;
  localparam int DEST_LSB   = 16;
  localparam int SRC0_MSB   = 15;
  localparam int SRC0_LSB   = 8;
  localparam int SRC1_MSB   = 7;
  localparam int SRC1_LSB   = 0;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch and IF/ID stage: owns the PC that addresses the
// combinational ROM and registers the returned word split into fields.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic                   oValid,
  output logic [ADDR_WIDTH-1:0]  oPC,
  output logic [3:0]             oOpcode,
  output logic [7:0]             oDest,
  output logic [7:0]             oSrc0,
  output logic [7:0]             oSrc1,
  output logic [15:0]            oImm16
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_pc_ifid;
  logic [3:0]            r_opcode;
  logic [7:0]            r_dest;
  logic [7:0]            r_src0;
  logic [7:0]            r_src1;

  logic                  w_jmp;
  logic [ADDR_WIDTH-1:0] w_jmp_target;

  // A JMP is acted on once it sits in IF/ID, so the redirect is one cycle late
  // and the sequential word fetched alongside it must be squashed.
  assign w_jmp        = r_valid && (r_opcode == OP_JMP);
  assign w_jmp_target = {{(ADDR_WIDTH-8){1'b0}}, r_dest};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else if (iBranchTaken) begin
      r_pc <= iBranchTarget;
    end else if (iStall) begin
      r_pc <= r_pc;
    end else if (w_jmp) begin
      r_pc <= w_jmp_target;
    end else begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || iBranchTaken) begin
      r_valid   <= 1'b0;
      r_pc_ifid <= '0;
      r_opcode  <= '0;
      r_dest    <= '0;
      r_src0    <= '0;
      r_src1    <= '0;
    end else if (iStall) begin
      r_valid   <= r_valid;
      r_pc_ifid <= r_pc_ifid;
      r_opcode  <= r_opcode;
      r_dest    <= r_dest;
      r_src0    <= r_src0;
      r_src1    <= r_src1;
    end else if (w_jmp) begin
      r_valid   <= 1'b0;
      r_pc_ifid <= '0;
      r_opcode  <= '0;
      r_dest    <= '0;
      r_src0    <= '0;
      r_src1    <= '0;
    end else begin
      r_valid   <= 1'b1;
      r_pc_ifid <= r_pc;
      r_opcode  <= iInstruction[OPCODE_MSB:OPCODE_LSB];
      r_dest    <= iInstruction[DEST_MSB:DEST_LSB];
      r_src0    <= iInstruction[SRC0_MSB:SRC0_LSB];
      r_src1    <= iInstruction[SRC1_MSB:SRC1_LSB];
    end
  end

  assign oAddress = r_pc;
  assign oValid   = r_valid;
  assign oPC      = r_pc_ifid;
  assign oOpcode  = r_opcode;
  assign oDest    = r_dest;
  assign oSrc0    = r_src0;
  assign oSrc1    = r_src1;
  assign oImm16   = {r_src0, r_src1};

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/branch/reset traffic, compared against a behavioural model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [27:0] instr;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        valid;
  logic [15:0] pc_out;
  logic [3:0]  opcode;
  logic [7:0]  dest;
  logic [7:0]  src0;
  logic [7:0]  src1;
  logic [15:0] imm16;

  logic [27:0] rom [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the fetch stage should hold after each edge.
  logic [15:0] m_pc;
  logic        m_valid;
  logic [15:0] m_ifid_pc;
  logic [27:0] m_word;

  always #5 clk = ~clk;

  assign instr = rom[addr[7:0]];

  instruction_fetch dut (
    .Clock        (clk),
    .Reset        (rst),
    .oAddress     (addr),
    .iInstruction (instr),
    .iStall       (stall),
    .iBranchTaken (br_taken),
    .iBranchTarget(br_target),
    .oValid       (valid),
    .oPC          (pc_out),
    .oOpcode      (opcode),
    .oDest        (dest),
    .oSrc0        (src0),
    .oSrc1        (src1),
    .oImm16       (imm16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the fetch rules in priority order.
  task automatic model_step(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic [27:0] fetched;
    fetched = rom[m_pc[7:0]];
    if (r) begin
      m_pc = 16'h0000; m_valid = 1'b0; m_ifid_pc = '0; m_word = '0;
    end else if (b) begin
      m_pc = t; m_valid = 1'b0; m_ifid_pc = '0; m_word = '0;
    end else if (s) begin
      // hold everything
    end else if (m_valid && m_word[27:24] == OP_JMP) begin
      m_pc = {8'h00, m_word[23:16]};
      m_valid = 1'b0; m_ifid_pc = '0; m_word = '0;
    end else begin
      m_ifid_pc = m_pc;
      m_word    = fetched;
      m_valid   = 1'b1;
      m_pc      = m_pc + 16'd1;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    @(negedge clk);
    rst = r; stall = s; br_taken = b; br_target = t;
    model_step(r, s, b, t);
    @(posedge clk);
    #1;
    check("addr",  {16'h0, addr},   {16'h0, m_pc});
    check("valid", {31'h0, valid},  {31'h0, m_valid});
    check("pc",    {16'h0, pc_out}, {16'h0, m_ifid_pc});
    check("opc",   {28'h0, opcode}, {28'h0, m_word[27:24]});
    check("dest",  {24'h0, dest},   {24'h0, m_word[23:16]});
    check("src0",  {24'h0, src0},   {24'h0, m_word[15:8]});
    check("src1",  {24'h0, src1},   {24'h0, m_word[7:0]});
    check("imm16", {16'h0, imm16},  {16'h0, m_word[15:0]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [27:0] w;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    m_pc = '0; m_valid = 1'b0; m_ifid_pc = '0; m_word = '0;

    // Random ROM with no accidental JMPs; jumps are placed explicitly.
    for (int i = 0; i < 256; i++) begin
      w = 28'($urandom);
      if (w[27:24] == OP_JMP) w[27:24] = OP_ADD;
      rom[i] = w;
    end
    rom[0] = {OP_STO, 8'd0, 16'd8};
    for (int i = 1; i < 4; i++) rom[i] = {OP_STO, 8'(i), 16'($urandom)};
    rom[16] = {OP_JMP, 8'd2, 16'($urandom)};

    // Reset and release: PC starts at RESET_PC with an empty IF/ID.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    check("rst_addr",  {16'h0, addr}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("first_pc",  {16'h0, pc_out}, 32'h0);
    check("first_val", {31'h0, valid}, 32'h1);
    check("first_opc", {28'h0, opcode}, {28'h0, OP_STO});
    check("first_dst", {24'h0, dest}, 32'h0);
    check("first_imm", {16'h0, imm16}, 32'd8);
    run(5);

    // Three stall cycles with oPC=5, then release to oPC=6.
    check("pre_stall_pc", {16'h0, pc_out}, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("stall_addr", {16'h0, addr}, 32'd6);
      check("stall_pc",   {16'h0, pc_out}, 32'd5);
      check("stall_val",  {31'h0, valid}, 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("release_pc", {16'h0, pc_out}, 32'd6);

    // Taken branch to 8 while oPC=12.
    run(6);
    check("pre_br_pc", {16'h0, pc_out}, 32'd12);
    step(1'b0, 1'b0, 1'b1, 16'd8);
    check("br_valid", {31'h0, valid}, 32'h0);
    check("br_addr",  {16'h0, addr}, 32'd8);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("br_tgt_pc",  {16'h0, pc_out}, 32'd8);
    check("br_tgt_val", {31'h0, valid}, 32'h1);

    // JMP at 16 targeting 2; the word at 17 must never become valid.
    run(8);
    check("jmp_pc",  {16'h0, pc_out}, 32'd16);
    check("jmp_opc", {28'h0, opcode}, {28'h0, OP_JMP});
    check("jmp_val", {31'h0, valid}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("jmp_bub_val", {31'h0, valid}, 32'h0);
    check("jmp_bub_addr", {16'h0, addr}, 32'd2);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("jmp_tgt_pc",  {16'h0, pc_out}, 32'd2);
    check("jmp_tgt_val", {31'h0, valid}, 32'h1);

    // JMP in IF/ID together with branch and stall: branch wins.
    run(14);
    check("jmp2_opc", {28'h0, opcode}, {28'h0, OP_JMP});
    step(1'b0, 1'b1, 1'b1, 16'd9);
    check("prio_addr", {16'h0, addr}, 32'd9);
    check("prio_val",  {31'h0, valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("prio_pc", {16'h0, pc_out}, 32'd9);

    // PC wrap from 16'hFFFF to 16'h0000.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_addr", {16'h0, addr}, 32'h0);
    check("wrap_pc",   {16'h0, pc_out}, 32'hFFFF);

    // Reset asserted in the middle of a five-cycle stall.
    run(3);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'd77);
    check("rst_stall_addr", {16'h0, addr}, 32'h0);
    check("rst_stall_val",  {31'h0, valid}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);

    // Randomized traffic with some jumps scattered through the ROM.
    for (int i = 0; i < 12; i++)
      rom[$urandom_range(40, 250)] = {OP_JMP, 8'($urandom), 16'($urandom)};
    for (int i = 0; i < 2000; i++) begin
      logic        r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 9) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                      : 16'($urandom_range(0, 255));
      step(r, s, b, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
